// File: rtl/seg_pipe_adder_pkg.sv
// adder_pkg: elaboration-time helpers shared by the segmented pipelined adder.
//   params_ok(width, seg) : 1 when width is a positive multiple of seg and seg >= 1
//   nstage(width, seg)    : number of carry segments / pipeline stages
package adder_pkg;

  function automatic bit params_ok(input int width, input int seg);
    return (seg >= 1) && (width >= seg) && ((width % seg) == 0);
  endfunction

  // Falls back to 1 on a bad SEG so the rest of the design still elaborates
  // far enough for the parameter error to be reported cleanly.
  function automatic int nstage(input int width, input int seg);
    return (seg >= 1) ? (width / seg) : 1;
  endfunction

endpackage

// File: rtl/seg_pipe_adder_if.sv
// seg_pipe_adder_if: operand/result streams of the segmented pipelined adder.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, s, cout, ovf
//   master = the block that supplies operands and consumes results
//   slave  = the adder itself
interface seg_pipe_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/seg_pipe_adder_seg_add.sv
// seg_add: combinational SEG-bit ripple-carry adder, one per pipeline stage.
//   a, b  : SEG-bit operands
//   ci    : carry in
//   s     : SEG-bit sum
//   co    : carry out of the top bit
//   c_msb : carry into the top bit (overflow detection in the last stage)
// Kept as its own unit so a carry-lookahead version can drop in unchanged.
module seg_add #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: WIDTH-bit add/subtract split into WIDTH/SEG carry segments,
// one register stage per segment, streaming one operation per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears all stage state
//   bus : seg_pipe_adder_if slave (operands in, result out, valid/ready each)
// sub=1 computes a - b - cin; cout is the raw carry (1 = no borrow).
module seg_pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic            clk,
  input  logic            rst,
  seg_pipe_adder_if.slave bus
);

  localparam int NSTAGE = nstage(WIDTH, SEG);

  if (!params_ok(WIDTH, SEG)) begin : g_param_err
    $error("seg_pipe_adder: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
  end

  // The whole pipeline moves as one; a stalled output freezes every stage.
  logic advance;
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    // Stage k sees only the operand bits not yet added (its own segment and
    // above) and produces the sum bits of its segment and everything below.
    localparam int W_IN  = WIDTH - k * SEG;
    localparam int W_SUM = (k + 1) * SEG;

    logic [W_IN-1:0]  a_in;
    logic [W_IN-1:0]  b_in;
    logic             c_in;
    logic             v_in;
    logic [SEG-1:0]   seg_s;
    logic             seg_co;
    logic             seg_cm;
    logic [W_SUM-1:0] sum_nxt;
    logic             vld_q;
    logic             c_q;
    logic [W_SUM-1:0] sum_q;

    if (k == 0) begin : g_src
      assign a_in    = bus.a;
      assign b_in    = bus.b ^ {WIDTH{bus.sub}};
      assign c_in    = bus.cin ^ bus.sub;
      assign v_in    = bus.in_valid;
      assign sum_nxt = seg_s;
    end else begin : g_src
      assign a_in    = g_stage[k-1].g_fwd.a_q;
      assign b_in    = g_stage[k-1].g_fwd.b_q;
      assign c_in    = g_stage[k-1].c_q;
      assign v_in    = g_stage[k-1].vld_q;
      assign sum_nxt = {seg_s, g_stage[k-1].sum_q};
    end

    seg_add #(.SEG(SEG)) u_seg_add (
      .a     (a_in[SEG-1:0]),
      .b     (b_in[SEG-1:0]),
      .ci    (c_in),
      .s     (seg_s),
      .co    (seg_co),
      .c_msb (seg_cm)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        vld_q <= v_in;
        c_q   <= seg_co;
        sum_q <= sum_nxt;
      end
    end

    if (k < NSTAGE - 1) begin : g_fwd
      // Operand bits for the later segments ride along untouched.
      logic [W_IN-SEG-1:0] a_q;
      logic [W_IN-SEG-1:0] b_q;
      logic                cm_unused;

      assign cm_unused = seg_cm;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[W_IN-1:SEG];
          b_q <= b_in[W_IN-1:SEG];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= seg_cm ^ seg_co;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[NSTAGE-1].vld_q;
  assign bus.s         = g_stage[NSTAGE-1].sum_q;
  assign bus.cout      = g_stage[NSTAGE-1].c_q;
  assign bus.ovf       = g_stage[NSTAGE-1].g_last.ovf_q;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Testbench for seg_pipe_adder: directed checks on an (8,4) instance plus
// exhaustive operand sweeps on (6,2), (6,6) and (3,1) instances with random
// in_valid / out_ready patterns.
module tb_seg_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Main (8,4) instance, driven directly.
  seg_pipe_adder_if #(.WIDTH(8)) dif ();
  seg_pipe_adder #(.WIDTH(8), .SEG(4)) u_dut (.clk(clk), .rst(rst), .bus(dif.slave));

  // Sweep instances, index 0:(6,2) 1:(6,6) 2:(3,1), reached through 8-bit lanes.
  logic [2:0]      sw_iv, sw_ir, sw_cin, sw_sub, sw_ov, sw_or, sw_co, sw_of;
  logic [2:0][7:0] sw_a, sw_b, sw_s;

  seg_pipe_adder_if #(.WIDTH(6)) if_62 ();
  seg_pipe_adder #(.WIDTH(6), .SEG(2)) u_62 (.clk(clk), .rst(rst), .bus(if_62.slave));
  seg_pipe_adder_if #(.WIDTH(6)) if_66 ();
  seg_pipe_adder #(.WIDTH(6), .SEG(6)) u_66 (.clk(clk), .rst(rst), .bus(if_66.slave));
  seg_pipe_adder_if #(.WIDTH(3)) if_31 ();
  seg_pipe_adder #(.WIDTH(3), .SEG(1)) u_31 (.clk(clk), .rst(rst), .bus(if_31.slave));

  assign if_62.in_valid  = sw_iv[0];
  assign if_62.a         = sw_a[0][5:0];
  assign if_62.b         = sw_b[0][5:0];
  assign if_62.cin       = sw_cin[0];
  assign if_62.sub       = sw_sub[0];
  assign if_62.out_ready = sw_or[0];
  assign sw_ir[0]        = if_62.in_ready;
  assign sw_ov[0]        = if_62.out_valid;
  assign sw_s[0]         = {2'b00, if_62.s};
  assign sw_co[0]        = if_62.cout;
  assign sw_of[0]        = if_62.ovf;

  assign if_66.in_valid  = sw_iv[1];
  assign if_66.a         = sw_a[1][5:0];
  assign if_66.b         = sw_b[1][5:0];
  assign if_66.cin       = sw_cin[1];
  assign if_66.sub       = sw_sub[1];
  assign if_66.out_ready = sw_or[1];
  assign sw_ir[1]        = if_66.in_ready;
  assign sw_ov[1]        = if_66.out_valid;
  assign sw_s[1]         = {2'b00, if_66.s};
  assign sw_co[1]        = if_66.cout;
  assign sw_of[1]        = if_66.ovf;

  assign if_31.in_valid  = sw_iv[2];
  assign if_31.a         = sw_a[2][2:0];
  assign if_31.b         = sw_b[2][2:0];
  assign if_31.cin       = sw_cin[2];
  assign if_31.sub       = sw_sub[2];
  assign if_31.out_ready = sw_or[2];
  assign sw_ir[2]        = if_31.in_ready;
  assign sw_ov[2]        = if_31.out_valid;
  assign sw_s[2]         = {5'b00000, if_31.s};
  assign sw_co[2]        = if_31.cout;
  assign sw_of[2]        = if_31.ovf;

  task automatic test_reset();
    rst = 1'b1;
    dif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dif.out_valid, dif.s, dif.cout, dif.ovf, dif.in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got valid=%b s=%h cout=%b ovf=%b in_ready=%b, want 0 00 0 0 1",
               dif.out_valid, dif.s, dif.cout, dif.ovf, dif.in_ready);
    end
    checks++;
    if ({sw_ov, sw_ir} !== 6'b000_111) begin
      errors++;
      $display("FAIL reset_sweep_dut: got out_valid=%b in_ready=%b, want 000 111", sw_ov, sw_ir);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_add_sub();
    logic [7:0] ta [8] = '{8'hFF, 8'h7F, 8'h80, 8'h05, 8'h05, 8'h80, 8'h0F, 8'h33};
    logic [7:0] tb [8] = '{8'h01, 8'h01, 8'h80, 8'h07, 8'h07, 8'h01, 8'h01, 8'h33};
    logic       tc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       tsb[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] es [8] = '{8'h00, 8'h80, 8'h00, 8'hFE, 8'hFD, 8'h7F, 8'h11, 8'h00};
    logic       ec [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       eo [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    dif.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      dif.in_valid = 1'b1;
      dif.a = ta[i];
      dif.b = tb[i];
      dif.cin = tc[i];
      dif.sub = tsb[i];
      @(posedge clk);
      #1 dif.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (dif.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL add_sub_latency[%0d]: got out_valid=%b one edge after accept, want 0", i, dif.out_valid);
      end
      @(negedge clk);
      checks++;
      if ({dif.out_valid, dif.s, dif.cout, dif.ovf} !== {1'b1, es[i], ec[i], eo[i]}) begin
        errors++;
        $display("FAIL add_sub[%0d]: got valid=%b s=%h cout=%b ovf=%b, want valid=1 s=%h cout=%b ovf=%b",
                 i, dif.out_valid, dif.s, dif.cout, dif.ovf, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [4] = '{8'h10, 8'h20, 8'h30, 8'hF0};
    logic [7:0] tb [4] = '{8'h01, 8'h02, 8'h03, 8'h20};
    logic [7:0] es [4] = '{8'h11, 8'h22, 8'h33, 8'h10};
    logic       ec [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    dif.out_ready = 1'b1;
    dif.cin = 1'b0;
    dif.sub = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) begin
        dif.in_valid = 1'b1;
        dif.a = ta[i];
        dif.b = tb[i];
      end else begin
        dif.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if ({dif.out_valid, dif.s, dif.cout} !== {1'b1, es[i-2], ec[i-2]}) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got valid=%b s=%h cout=%b, want valid=1 s=%h cout=%b",
                   i - 2, dif.out_valid, dif.s, dif.cout, es[i-2], ec[i-2]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (dif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_drain: got out_valid=%b, want 0", dif.out_valid);
    end
  endtask

  task automatic test_backpressure();
    dif.out_ready = 1'b0;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b1; dif.a = 8'h12; dif.b = 8'h34; dif.cin = 1'b0; dif.sub = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_empty_ready: got in_ready=%b, want 1", dif.in_ready);
    end
    @(posedge clk);
    #1;
    dif.a = 8'hA0; dif.b = 8'h10; dif.cin = 1'b0; dif.sub = 1'b1;
    @(posedge clk);
    #1;
    dif.a = 8'h01; dif.b = 8'h01; dif.cin = 1'b1; dif.sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({dif.in_ready, dif.out_valid, dif.s, dif.cout, dif.ovf} !== {1'b0, 1'b1, 8'h46, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got in_ready=%b valid=%b s=%h cout=%b ovf=%b, want 0 1 46 0 0",
                 i, dif.in_ready, dif.out_valid, dif.s, dif.cout, dif.ovf);
      end
      @(posedge clk);
      #1;
    end
    dif.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({dif.in_ready, dif.out_valid, dif.s} !== {1'b1, 1'b1, 8'h46}) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b valid=%b s=%h, want 1 1 46",
               dif.in_ready, dif.out_valid, dif.s);
    end
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({dif.out_valid, dif.s, dif.cout} !== {1'b1, 8'h90, 1'b1}) begin
      errors++;
      $display("FAIL bp_drain1: got valid=%b s=%h cout=%b, want 1 90 1", dif.out_valid, dif.s, dif.cout);
    end
    @(negedge clk);
    checks++;
    if ({dif.out_valid, dif.s} !== {1'b1, 8'h03}) begin
      errors++;
      $display("FAIL bp_drain2: got valid=%b s=%h, want 1 03", dif.out_valid, dif.s);
    end
    @(negedge clk);
    checks++;
    if (dif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got out_valid=%b, want 0", dif.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b1; dif.a = 8'h55; dif.b = 8'h22; dif.cin = 1'b0; dif.sub = 1'b0;
    @(posedge clk);
    #1;
    dif.a = 8'h11; dif.b = 8'h11;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dif.out_valid, dif.s} !== {1'b1, 8'h77}) begin
      errors++;
      $display("FAIL rst_mid_before: got valid=%b s=%h, want 1 77", dif.out_valid, dif.s);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dif.out_valid, dif.s, dif.cout, dif.ovf} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_after: got valid=%b s=%h cout=%b ovf=%b, want 0 00 0 0",
               dif.out_valid, dif.s, dif.cout, dif.ovf);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (dif.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_stale[%0d]: got out_valid=%b, want 0", i, dif.out_valid);
      end
    end
  endtask

  // Enumerates every {sub, cin, b, a} in order; random bubbles and stalls
  // change only timing, so results must come back in the same order.
  task automatic sweep(input int set, input int w);
    int total = 1 << (2 * w + 2);
    int mask  = (1 << w) - 1;
    int sent  = 0;
    int got   = 0;
    int cyc   = 0;
    int av, bv, cv, sv, be, full, es, ec, eo;
    sw_iv[set] = 1'b0;
    sw_or[set] = 1'b0;
    while ((sent < total || got < total) && cyc < 60000) begin
      @(posedge clk);
      #1;
      sw_iv[set]  = (sent < total) && ($urandom_range(3) != 0);
      sw_a[set]   = 8'(sent & mask);
      sw_b[set]   = 8'((sent >> w) & mask);
      sw_cin[set] = 1'((sent >> (2 * w)) & 1);
      sw_sub[set] = 1'((sent >> (2 * w + 1)) & 1);
      sw_or[set]  = ($urandom_range(3) != 0);
      @(negedge clk);
      if (sw_ov[set] && sw_or[set]) begin
        av   = got & mask;
        bv   = (got >> w) & mask;
        cv   = (got >> (2 * w)) & 1;
        sv   = (got >> (2 * w + 1)) & 1;
        be   = (sv != 0) ? (bv ^ mask) : bv;
        full = av + be + (cv ^ sv);
        es   = full & mask;
        ec   = (full >> w) & 1;
        eo   = ((((av >> (w - 1)) & 1) == ((be >> (w - 1)) & 1)) &&
                (((es >> (w - 1)) & 1) != ((av >> (w - 1)) & 1))) ? 1 : 0;
        checks++;
        if ({sw_co[set], sw_of[set], sw_s[set]} !== {1'(ec), 1'(eo), 8'(es)}) begin
          errors++;
          $display("FAIL sweep[%0d] op %0d: got cout=%b ovf=%b s=%h, want cout=%b ovf=%b s=%h",
                   set, got, sw_co[set], sw_of[set], sw_s[set], ec[0], eo[0], 8'(es));
        end
        got++;
      end
      if (sw_iv[set] && sw_ir[set]) sent++;
      cyc++;
    end
    checks++;
    if (sent != total || got != total) begin
      errors++;
      $display("FAIL sweep_count[%0d]: got sent=%0d results=%0d, want %0d each", set, sent, got, total);
    end
    sw_iv[set] = 1'b0;
    sw_or[set] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sw_ov[set] !== 1'b0) begin
        errors++;
        $display("FAIL sweep_extra[%0d]: got out_valid=%b after last result, want 0", set, sw_ov[set]);
      end
    end
  endtask

  task automatic test_exhaustive();
    fork
      sweep(0, 6);
      sweep(1, 6);
      sweep(2, 3);
    join
  endtask

  initial begin
    rst           = 1'b1;
    dif.in_valid  = 1'b0;
    dif.a         = 8'h00;
    dif.b         = 8'h00;
    dif.cin       = 1'b0;
    dif.sub       = 1'b0;
    dif.out_ready = 1'b0;
    sw_iv  = '0;
    sw_or  = '0;
    sw_cin = '0;
    sw_sub = '0;
    sw_a   = '0;
    sw_b   = '0;
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
